prog_mem: RTL and testbench

Parametrised, loadable instruction memory for the 16-bit core; next generation of the fixed-table instruction store. It serves the fetch stage with a one-cycle registered read and accepts program loads through a write port. On reset it sweeps every word to a fill pattern, so unprogrammed and out-of-range fetches return a known value. A lock mode makes the program read-only until the next reset.

---
 rtl/prog_mem_if.sv | 30 +++
 rtl/prog_mem.sv | 98 +++++++++
 tb/tb_prog_mem.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_if.sv
// Fetch and program-load signal bundle for prog_mem.
// master = core/loader side, slave = memory side.
interface prog_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] PC;
  logic              fetch_req;
  logic              fetch_stall;
  logic [DATA_W-1:0] INSTR;
  logic              instr_valid;
  logic              oob;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              lock;
  logic              locked;
  logic              wr_err;
  logic              ready;

  modport master (
    output PC, fetch_req, fetch_stall, load_we, load_addr, load_data, lock,
    input  INSTR, instr_valid, oob, locked, wr_err, ready
  );

  modport slave (
    input  PC, fetch_req, fetch_stall, load_we, load_addr, load_data, lock,
    output INSTR, instr_valid, oob, locked, wr_err, ready
  );
endinterface

// File: rtl/prog_mem.sv
// Loadable instruction memory: 1-cycle registered fetch, write-first load port,
// reset sweep to FILL, sticky write lock.
module prog_mem #(
  parameter int               DATA_W = 16,
  parameter int               ADDR_W = 16,
  parameter int               DEPTH  = 64,
  parameter logic [DATA_W-1:0] FILL  = {DATA_W{1'b1}}
) (
  input logic        clk,
  input logic        rst_n,
  prog_mem_if.slave  bus
);
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] instr_q;
  logic              valid_q, oob_q, ready_q, locked_q, wr_err_q;

  logic              pc_in, la_in, fetch_acc, wr_acc;
  logic [IDX_W-1:0]  pc_idx, la_idx;

  // Range checks use the full address width so high bits never alias into the array.
  always_comb begin
    pc_in     = {1'b0, bus.PC} < DEPTH_X;
    la_in     = {1'b0, bus.load_addr} < DEPTH_X;
    pc_idx    = bus.PC[IDX_W-1:0];
    la_idx    = bus.load_addr[IDX_W-1:0];
    fetch_acc = ready_q & bus.fetch_req & ~bus.fetch_stall;
    wr_acc    = (state == RUN) & bus.load_we & ~locked_q & la_in;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT)
        mem[clr_idx] <= FILL;
      else if (wr_acc)
        mem[la_idx] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      clr_idx  <= '0;
      instr_q  <= FILL;
      valid_q  <= 1'b0;
      oob_q    <= 1'b0;
      ready_q  <= 1'b0;
      locked_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.load_we & ~wr_acc;
      case (state)
        INIT: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.lock) locked_q <= 1'b1;
        end
        default: state <= INIT;
      endcase

      if (!bus.fetch_stall) begin
        if (fetch_acc) begin
          valid_q <= 1'b1;
          if (!pc_in) begin
            instr_q <= FILL;
            oob_q   <= 1'b1;
          end else begin
            // Write-first: a same-cycle load to the fetched word bypasses the array.
            instr_q <= (wr_acc && la_idx == pc_idx) ? bus.load_data : mem[pc_idx];
            oob_q   <= 1'b0;
          end
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.INSTR       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.oob         = oob_q;
  assign bus.ready       = ready_q;
  assign bus.locked      = locked_q;
  assign bus.wr_err      = wr_err_q;
endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem (DEPTH=8): directed vector table, reset/init
// sequences, and randomized traffic against an array-based reference model.
module tb_prog_mem;
  logic clk = 1'b0;
  logic rst_n;
  int   npass = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  prog_mem_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  prog_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .FILL(16'hFFFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] pc;
    logic        req, stall, we;
    logic [15:0] addr, data;
    logic        lk;
    logic [15:0] e_instr;
    logic        e_valid, e_oob, e_wrerr, e_locked;
  } vec_t;

  vec_t        vt[$];
  logic [15:0] mm [8];
  logic        mlock;
  logic [15:0] e_instr;
  logic        e_valid, e_oob;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic drive(logic [15:0] pc, logic req, logic stall, logic we,
                       logic [15:0] addr, logic [15:0] data, logic lk);
    bus.PC = pc; bus.fetch_req = req; bus.fetch_stall = stall;
    bus.load_we = we; bus.load_addr = addr; bus.load_data = data; bus.lock = lk;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mm[i] = 16'hFFFF;
    mlock = 1'b0; e_instr = 16'hFFFF; e_valid = 1'b0; e_oob = 1'b0;
  endtask

  task automatic run_init();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("init_ready", bus.ready, (k == 8));
      chk("init_valid", bus.instr_valid, 1'b0);
    end
    model_reset();
  endtask

  // One RUN-mode cycle checked against the reference model.
  task automatic mstep(logic [15:0] pc, logic req, logic stall, logic we,
                       logic [15:0] addr, logic [15:0] data, logic lk);
    bit ok, e_err;
    ok    = we && !mlock && (addr < 16'd8);
    e_err = we && !ok;
    if (!stall) begin
      if (req) begin
        e_valid = 1'b1;
        if (pc < 16'd8) begin
          e_instr = (ok && addr == pc) ? data : mm[pc];
          e_oob   = 1'b0;
        end else begin
          e_instr = 16'hFFFF;
          e_oob   = 1'b1;
        end
      end else begin
        e_valid = 1'b0;
      end
    end
    if (ok) mm[addr] = data;
    drive(pc, req, stall, we, addr, data, lk);
    cyc();
    if (lk) mlock = 1'b1;
    chk("m_instr",  bus.INSTR, e_instr);
    chk("m_valid",  bus.instr_valid, e_valid);
    chk("m_oob",    bus.oob, e_oob);
    chk("m_wrerr",  bus.wr_err, e_err);
    chk("m_locked", bus.locked, mlock);
    chk("m_ready",  bus.ready, 1'b1);
  endtask

  initial begin
    //            pc       req stall we  addr     data      lk  instr     v  oob err lck
    vt.push_back('{16'd0,     1, 0, 0, 16'd0,  16'h0000, 0, 16'hFFFF, 1, 0, 0, 0});
    vt.push_back('{16'd7,     1, 0, 0, 16'd0,  16'h0000, 0, 16'hFFFF, 1, 0, 0, 0});
    vt.push_back('{16'd0,     0, 0, 1, 16'd1,  16'h3000, 0, 16'hFFFF, 0, 0, 0, 0});
    vt.push_back('{16'd1,     1, 0, 0, 16'd0,  16'h0000, 0, 16'h3000, 1, 0, 0, 0});
    vt.push_back('{16'd0,     1, 0, 0, 16'd0,  16'h0000, 0, 16'hFFFF, 1, 0, 0, 0});
    vt.push_back('{16'd2,     1, 0, 1, 16'd2,  16'h1234, 0, 16'h1234, 1, 0, 0, 0});
    vt.push_back('{16'd5,     1, 1, 0, 16'd0,  16'h0000, 0, 16'h1234, 1, 0, 0, 0});
    vt.push_back('{16'd5,     1, 1, 0, 16'd0,  16'h0000, 0, 16'h1234, 1, 0, 0, 0});
    vt.push_back('{16'd5,     1, 1, 0, 16'd0,  16'h0000, 0, 16'h1234, 1, 0, 0, 0});
    vt.push_back('{16'd8,     1, 0, 0, 16'd0,  16'h0000, 0, 16'hFFFF, 1, 1, 0, 0});
    vt.push_back('{16'hFFFF,  1, 0, 0, 16'd0,  16'h0000, 0, 16'hFFFF, 1, 1, 0, 0});
    vt.push_back('{16'd0,     0, 0, 1, 16'd8,  16'h7777, 0, 16'hFFFF, 0, 1, 1, 0});
    vt.push_back('{16'd0,     1, 0, 0, 16'd0,  16'h0000, 0, 16'hFFFF, 1, 0, 0, 0});
    vt.push_back('{16'd1,     1, 0, 1, 16'd9,  16'h4444, 0, 16'h3000, 1, 0, 1, 0});
    vt.push_back('{16'd0,     1, 0, 1, 16'h10, 16'h6666, 0, 16'hFFFF, 1, 0, 1, 0});
    vt.push_back('{16'd0,     0, 0, 1, 16'd3,  16'h5555, 1, 16'hFFFF, 0, 0, 0, 1});
    vt.push_back('{16'd0,     0, 0, 1, 16'd1,  16'hABCD, 0, 16'hFFFF, 0, 0, 1, 1});
    vt.push_back('{16'd1,     1, 0, 0, 16'd0,  16'h0000, 0, 16'h3000, 1, 0, 0, 1});
    vt.push_back('{16'd3,     1, 0, 0, 16'd0,  16'h0000, 0, 16'h5555, 1, 0, 0, 1});
    vt.push_back('{16'd3,     0, 1, 0, 16'd0,  16'h0000, 0, 16'h5555, 1, 0, 0, 1});
    vt.push_back('{16'd3,     0, 0, 0, 16'd0,  16'h0000, 0, 16'h5555, 0, 0, 0, 1});

    // Reset state, with fetch and load activity that must be ignored.
    rst_n = 1'b0;
    drive(16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0);
    cyc(); cyc();
    chk("rst_instr",  bus.INSTR, 16'hFFFF);
    chk("rst_valid",  bus.instr_valid, 1'b0);
    chk("rst_oob",    bus.oob, 1'b0);
    chk("rst_ready",  bus.ready, 1'b0);
    chk("rst_locked", bus.locked, 1'b0);
    chk("rst_wrerr",  bus.wr_err, 1'b0);

    // Load during INIT is rejected with a one-cycle pulse.
    rst_n = 1'b1;
    bus.load_we = 1'b1;
    cyc();
    chk("init_wrerr", bus.wr_err, 1'b1);
    chk("init_ready", bus.ready, 1'b0);
    bus.load_we = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      cyc();
      chk("init_ready", bus.ready, (k == 8));
      chk("init_valid", bus.instr_valid, 1'b0);
      if (k == 2) chk("init_wrerr_clr", bus.wr_err, 1'b0);
    end

    // Directed vector table.
    foreach (vt[i]) begin
      drive(vt[i].pc, vt[i].req, vt[i].stall, vt[i].we, vt[i].addr, vt[i].data, vt[i].lk);
      cyc();
      chk($sformatf("v%0d_instr", i),  bus.INSTR, vt[i].e_instr);
      chk($sformatf("v%0d_valid", i),  bus.instr_valid, vt[i].e_valid);
      chk($sformatf("v%0d_oob", i),    bus.oob, vt[i].e_oob);
      chk($sformatf("v%0d_wrerr", i),  bus.wr_err, vt[i].e_wrerr);
      chk($sformatf("v%0d_locked", i), bus.locked, vt[i].e_locked);
    end

    // Reset during RUN after loads and lock: lock clears, contents swept.
    drive(16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0);
    rst_n = 1'b0;
    cyc();
    chk("rrun_locked", bus.locked, 1'b0);
    chk("rrun_ready",  bus.ready, 1'b0);
    chk("rrun_instr",  bus.INSTR, 16'hFFFF);
    chk("rrun_valid",  bus.instr_valid, 1'b0);
    run_init();
    for (int p = 0; p < 8; p++) mstep(16'(p), 1'b1, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0);

    // Load some words, then reset mid-INIT: sweep restarts from zero.
    for (int p = 0; p < 8; p++) mstep(16'd0, 1'b0, 1'b0, 1'b1, 16'(p), 16'(p + 16'h0A00), 1'b0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    rst_n = 1'b0;
    cyc();
    chk("rinit_ready", bus.ready, 1'b0);
    run_init();
    for (int p = 0; p < 8; p++) mstep(16'(p), 1'b1, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 500; c++) begin
      logic [15:0] r_pc, r_addr;
      r_pc   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
      r_addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
      mstep(r_pc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)), r_addr, 16'($urandom), 1'($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
